// File: rtl/exec_issue_arbiter.sv
// Round-robin issue arbiter feeding a shared execute unit,
// with an issue register and a handshaked result register.
package exec_pkg;
   typedef enum logic [3:0] {
      IT_OP     = 4'd0,
      IT_OPIMM  = 4'd1,
      IT_LUI    = 4'd2,
      IT_AUIPC  = 4'd3,
      IT_BRANCH = 4'd4,
      IT_JAL    = 4'd5,
      IT_JALR   = 4'd6,
      IT_LOAD   = 4'd7,
      IT_STORE  = 4'd8
   } iType_t;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_SLTU = 4'd6,
      ALU_SLL  = 4'd7,
      ALU_SRL  = 4'd8,
      ALU_SRA  = 4'd9
   } aluFunc_t;

   typedef enum logic [2:0] {
      BR_EQ  = 3'd0,
      BR_NE  = 3'd1,
      BR_LT  = 3'd2,
      BR_GE  = 3'd3,
      BR_LTU = 3'd4,
      BR_GEU = 3'd5,
      BR_AT  = 3'd6,
      BR_NT  = 3'd7
   } brFunc_t;
endpackage

module exec_issue_arbiter
   import exec_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = 4
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic                          flush_in,
   input  logic [NUM_REQ-1:0]            req_valid_in,
   output logic [NUM_REQ-1:0]            req_ready_out,
   input  iType_t   [NUM_REQ-1:0]        req_iType_in,
   input  aluFunc_t [NUM_REQ-1:0]        req_aluFunc_in,
   input  brFunc_t  [NUM_REQ-1:0]        req_brFunc_in,
   input  logic [NUM_REQ-1:0][31:0]      req_imm_in,
   input  logic [NUM_REQ-1:0][31:0]      req_pc_in,
   input  logic [NUM_REQ-1:0][31:0]      req_rval1_in,
   input  logic [NUM_REQ-1:0][31:0]      req_rval2_in,
   input  logic [NUM_REQ-1:0][TAG_W-1:0] req_tag_in,
   output iType_t                        ex_iType_out,
   output aluFunc_t                      ex_aluFunc_out,
   output brFunc_t                       ex_brFunc_out,
   output logic [31:0]                   ex_imm_out,
   output logic [31:0]                   ex_pc_out,
   output logic [31:0]                   ex_rval1_out,
   output logic [31:0]                   ex_rval2_out,
   input  logic [31:0]                   ex_data_in,
   input  logic [31:0]                   ex_addr_in,
   input  logic [31:0]                   ex_nextPc_in,
   output logic                          res_valid_out,
   input  logic                          res_ready_in,
   output logic [31:0]                   res_data_out,
   output logic [31:0]                   res_addr_out,
   output logic [31:0]                   res_nextPc_out,
   output logic [TAG_W-1:0]              res_tag_out,
   output iType_t                        res_iType_out
);

   localparam int PTR_W = $clog2(NUM_REQ);

   logic             iss_valid_q, iss_valid_d;
   logic             res_valid_q, res_valid_d;
   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

   iType_t     iss_itype_q, iss_itype_d;
   aluFunc_t   iss_alu_q, iss_alu_d;
   brFunc_t    iss_br_q, iss_br_d;
   logic [31:0] iss_imm_q, iss_imm_d;
   logic [31:0] iss_pc_q, iss_pc_d;
   logic [31:0] iss_rv1_q, iss_rv1_d;
   logic [31:0] iss_rv2_q, iss_rv2_d;
   logic [TAG_W-1:0] iss_tag_q, iss_tag_d;

   logic [31:0]      res_data_q, res_data_d;
   logic [31:0]      res_addr_q, res_addr_d;
   logic [31:0]      res_npc_q, res_npc_d;
   logic [TAG_W-1:0] res_tag_q, res_tag_d;
   iType_t           res_itype_q, res_itype_d;

   logic               res_adv;
   logic               iss_adv;
   logic               gnt_any;
   logic [PTR_W-1:0]   gnt_idx;
   logic [NUM_REQ-1:0] gnt;

   // Explicit modulo wrap so non-power-of-2 NUM_REQ works.
   function automatic logic [PTR_W-1:0] wrap_add(
      input logic [PTR_W-1:0] p,
      input int               k
   );
      int s;
      s = int'(p) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return s[PTR_W-1:0];
   endfunction

   assign res_adv = !res_valid_q || res_ready_in;
   assign iss_adv = !iss_valid_q || res_adv;

   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      gnt     = '0;
      if (iss_adv && !flush_in && !rst_in) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (!gnt_any && req_valid_in[wrap_add(rr_ptr_q, k)]) begin
               gnt_any = 1'b1;
               gnt_idx = wrap_add(rr_ptr_q, k);
            end
         end
      end
      if (gnt_any) gnt[gnt_idx] = 1'b1;
   end

   assign req_ready_out = gnt;

   always_comb begin
      iss_valid_d = iss_valid_q;
      res_valid_d = res_valid_q;
      rr_ptr_d    = rr_ptr_q;
      iss_itype_d = iss_itype_q;
      iss_alu_d   = iss_alu_q;
      iss_br_d    = iss_br_q;
      iss_imm_d   = iss_imm_q;
      iss_pc_d    = iss_pc_q;
      iss_rv1_d   = iss_rv1_q;
      iss_rv2_d   = iss_rv2_q;
      iss_tag_d   = iss_tag_q;
      res_data_d  = res_data_q;
      res_addr_d  = res_addr_q;
      res_npc_d   = res_npc_q;
      res_tag_d   = res_tag_q;
      res_itype_d = res_itype_q;

      if (res_adv) begin
         res_valid_d = iss_valid_q;
         res_data_d  = ex_data_in;
         res_addr_d  = ex_addr_in;
         res_npc_d   = ex_nextPc_in;
         res_tag_d   = iss_tag_q;
         res_itype_d = iss_itype_q;
      end

      if (iss_adv) begin
         iss_valid_d = gnt_any;
         if (gnt_any) begin
            iss_itype_d = req_iType_in[gnt_idx];
            iss_alu_d   = req_aluFunc_in[gnt_idx];
            iss_br_d    = req_brFunc_in[gnt_idx];
            iss_imm_d   = req_imm_in[gnt_idx];
            iss_pc_d    = req_pc_in[gnt_idx];
            iss_rv1_d   = req_rval1_in[gnt_idx];
            iss_rv2_d   = req_rval2_in[gnt_idx];
            iss_tag_d   = req_tag_in[gnt_idx];
            rr_ptr_d    = wrap_add(gnt_idx, 1);
         end
      end

      // Flush kills whatever is in flight; an accepted result already left.
      if (flush_in) begin
         iss_valid_d = 1'b0;
         res_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         iss_valid_q <= 1'b0;
         res_valid_q <= 1'b0;
         rr_ptr_q    <= '0;
         iss_itype_q <= IT_OP;
         iss_alu_q   <= ALU_ADD;
         iss_br_q    <= BR_EQ;
         iss_imm_q   <= '0;
         iss_pc_q    <= '0;
         iss_rv1_q   <= '0;
         iss_rv2_q   <= '0;
         iss_tag_q   <= '0;
         res_data_q  <= '0;
         res_addr_q  <= '0;
         res_npc_q   <= '0;
         res_tag_q   <= '0;
         res_itype_q <= IT_OP;
      end else begin
         iss_valid_q <= iss_valid_d;
         res_valid_q <= res_valid_d;
         rr_ptr_q    <= rr_ptr_d;
         iss_itype_q <= iss_itype_d;
         iss_alu_q   <= iss_alu_d;
         iss_br_q    <= iss_br_d;
         iss_imm_q   <= iss_imm_d;
         iss_pc_q    <= iss_pc_d;
         iss_rv1_q   <= iss_rv1_d;
         iss_rv2_q   <= iss_rv2_d;
         iss_tag_q   <= iss_tag_d;
         res_data_q  <= res_data_d;
         res_addr_q  <= res_addr_d;
         res_npc_q   <= res_npc_d;
         res_tag_q   <= res_tag_d;
         res_itype_q <= res_itype_d;
      end
   end

   assign ex_iType_out   = iss_itype_q;
   assign ex_aluFunc_out = iss_alu_q;
   assign ex_brFunc_out  = iss_br_q;
   assign ex_imm_out     = iss_imm_q;
   assign ex_pc_out      = iss_pc_q;
   assign ex_rval1_out   = iss_rv1_q;
   assign ex_rval2_out   = iss_rv2_q;

   assign res_valid_out  = res_valid_q;
   assign res_data_out   = res_data_q;
   assign res_addr_out   = res_addr_q;
   assign res_nextPc_out = res_npc_q;
   assign res_tag_out    = res_tag_q;
   assign res_iType_out  = res_itype_q;

endmodule

// File: doc/exec_issue_arbiter.md
# exec_issue_arbiter

Round-robin arbiter and two-stage sequencer that shares one `execute` unit among `NUM_REQ` reservation-station requesters in the out-of-order core. A granted request is captured into an issue register that drives the `execute` inputs. One cycle later, the `execute` outputs (`data_out`, `addr_out`, `nextPc_out`) are captured with the request's ROB tag into a result register. The result register presents them to the CDB/ROB writer over a valid/ready handshake, with backpressure and flush.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (≥2).
- `TAG_W`, 4: ROB tag width.

Ports:
- `clk_in` input 1: single clock; all state updates on the rising edge.
- `rst_in` input 1: synchronous, active-high reset.
- `flush_in` input 1: pipeline flush (mispredict/exception).
- `req_valid_in` input `NUM_REQ`: per-requester operation valid.
- `req_ready_out` output `NUM_REQ`: one-hot grant; a transfer occurs when valid and ready are both high.
- `req_iType_in`, `req_aluFunc_in`, `req_brFunc_in` input `NUM_REQ` × package type: decoded operation per requester.
- `req_imm_in`, `req_pc_in`, `req_rval1_in`, `req_rval2_in` input `NUM_REQ` × 32: operands per requester.
- `req_tag_in` input `NUM_REQ` × `TAG_W`: ROB tag per requester.
- `ex_iType_out`, `ex_aluFunc_out`, `ex_brFunc_out`, `ex_imm_out`, `ex_pc_out`, `ex_rval1_out`, `ex_rval2_out` output: issue-register contents, wired to the `execute` inputs.
- `ex_data_in`, `ex_addr_in`, `ex_nextPc_in` input 32: combinational `execute` results.
- `res_valid_out` output 1: result register holds a valid result.
- `res_ready_in` input 1: consumer accepts the result.
- `res_data_out`, `res_addr_out`, `res_nextPc_out` output 32: registered results.
- `res_tag_out` output `TAG_W`: ROB tag of the result.
- `res_iType_out` output type: operation type, so the consumer can recognise BRANCH/JAL/JALR/STORE.

## Operation
- **Result stage.**
  - `res_adv = !res_valid || res_ready_in`.
  - When `res_adv` holds, the result register loads `{iss_valid, ex_*_in, iss_tag, iss_iType}`.
- **Issue stage.**
  - `iss_adv = !iss_valid || res_adv`.
  - When `iss_adv` holds, the issue register loads the granted request, or clears `iss_valid` if there is no grant.
- **Grant rules.**
  - A grant is made only when `iss_adv && !flush_in && !rst_in`.
  - Search starts at `rr_ptr` and wraps modulo `NUM_REQ`; the first requester with `req_valid_in` set wins.
  - `req_ready_out` is combinational and at most one-hot. It is all-zero when no grant is made.
- **Pointer update.** After a grant to requester i, `rr_ptr` ← (i+1) mod `NUM_REQ`. With no grant, `rr_ptr` holds.
- **Held results.** While `res_valid_out && !res_ready_in`, the result register holds steady (stable-while-valid). The issue register also holds if it is valid.
  - `execute` is combinational, so the held issue register keeps `ex_*_in` stable.
- **Idle issue register.** When the issue register is invalid, `ex_*_out` hold their last values. Downstream logic ignores them.
- **Flush.**
  - On a flush cycle, the next edge clears `iss_valid` and `res_valid`.
  - No grant is made and `rr_ptr` holds.
  - A result being accepted in the flush cycle (`res_valid_out && res_ready_in`) counts as delivered.
- **Reset.**
  - Clears `iss_valid`, `res_valid` and `rr_ptr` (=0).
  - Clears `ex_*_out`, `res_data/addr/nextPc/tag_out` to 0.
  - Sets `ex_iType_out` and `res_iType_out` to the package's zero encoding.
  - While reset is high, `req_ready_out` = 0.
- **Arithmetic.** No arithmetic on data. The `rr_ptr` width is $clog2(`NUM_REQ`); the wrap is explicit for non-power-of-2 values.

## Timing
- **Latency.** A handshake at edge N makes `ex_*_out` valid after N. The result is visible on `res_*_out` after edge N+1.
- **Throughput.** One operation per cycle when `res_ready_in` stays high.
- **Storage.** Maximum in-flight count is 2 (issue register plus result register); there is no further buffering.
- **Stall response.**
  - Deasserting `res_ready_in` while both stages are full drops `req_ready_out` to 0 in the same cycle.
  - Grants resume in the cycle `res_ready_in` returns high.
- **Combinational paths.**
  - `req_valid_in`, `res_ready_in`, `flush_in` → `req_ready_out` are combinational.
  - There is no combinational path from `req_*` to `res_*`.

## Test plan
- **Round robin:**
  - Stimulus: all 4 requesters valid continuously, `res_ready_in`=1.
  - Required: grants go 0,1,2,3,0,…, one per cycle. Tags appear on `res_tag_out` in the same order, 2 cycles after each grant.
- **Pass-through:**
  - Stimulus: single OPIMM ADD from requester 2 with `rval1`=5, `imm`=7, `pc`=0x100, tag=3.
  - Required: 2 cycles later `res_valid_out`=1, `res_data_out`=12, `res_nextPc_out`=0x104, `res_tag_out`=3.
- **Backpressure:**
  - Stimulus: `res_ready_in`=0 for 5 cycles with requesters continuously valid.
  - Required: exactly 2 grants, then `req_ready_out`=0. `res_*_out` is stable throughout. After release, no loss or duplication, in order.
- **Flush:**
  - Stimulus: assert `flush_in` with both stages valid.
  - Required: next cycle `res_valid_out`=0, no grant in the flush cycle, and `rr_ptr` unchanged (the next grant goes to the expected requester).
- **Reset mid-stream:**
  - Stimulus: assert `rst_in` for 1 cycle during a busy stream.
  - Required: all valids are 0, `req_ready_out`=0 during reset, and the first grant after reset goes to requester 0.
- **Sparse requests:**
  - Stimulus: only requesters 1 and 3 valid, `rr_ptr`=2.
  - Required: grant order 3,1,3,1.
